imm_gen_stage: RTL

- Registered, parametrised successor to the combinational immediate extender.
- Sits between the instruction-fetch buffer and the decode/execute boundary. Takes a raw instruction plus its format type and emits the sign/zero-extended immediate, one cycle later.
- Full-throughput valid/ready handshake with a 2-entry skid buffer; output stalls do not create combinational ready paths.
- Generalised to XLEN 32/64 and to the CSR zimm format. Illegal types are flagged and counted instead of aborting the simulation.

---
 rtl/imm_gen_stage_pkg.sv | 21 ++
 rtl/imm_gen_stage_imm_decode.sv | 27 ++
 rtl/imm_gen_stage.sv | 71 +++++++
 3 files changed

// File: rtl/imm_gen_stage_pkg.sv
// imm_gen_stage_pkg: shared type codes, bus widths, skid states and abort codes for imm_gen_stage
package imm_gen_stage_pkg;
  localparam int TYPE_BUS_W = 3;
  localparam int ABORT = 1;
  localparam int UNIT_IE4 = 4;
  typedef enum logic [TYPE_BUS_W-1:0] {
    T_R   = 3'd0,
    T_I   = 3'd1,
    T_S   = 3'd2,
    T_B   = 3'd3,
    T_U   = 3'd4,
    T_J   = 3'd5,
    T_Z   = 3'd6,
    T_ILL = 3'd7
  } imm_type_e;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;
endpackage

// File: rtl/imm_gen_stage_imm_decode.sv
// imm_decode: combinational instruction + format type to extended immediate and illegal flag
module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int TYPE_W = TYPE_BUS_W
) (
  input  logic [31:0]       inst,
  input  logic [TYPE_W-1:0] typ,
  output logic [XLEN-1:0]   imm,
  output logic              illegal
);
  logic [63:0] wide;
  logic        unused_bits;
  always_comb begin
    illegal = typ > TYPE_W'(T_Z);
    wide = typ == TYPE_W'(T_I) ? {{52{inst[31]}}, inst[31:20]} :
           typ == TYPE_W'(T_S) ? {{52{inst[31]}}, inst[31:25], inst[11:7]} :
           typ == TYPE_W'(T_B) ? {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
           typ == TYPE_W'(T_U) ? {{32{inst[31]}}, inst[31:12], 12'b0} :
           typ == TYPE_W'(T_J) ? {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
           typ == TYPE_W'(T_Z) ? {59'b0, inst[19:15]} :
           64'b0;
    imm = wide[XLEN-1:0];
  end
  assign unused_bits = ^{inst[6:0], wide};
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate generator with 2-entry skid buffer and saturating illegal counter (IMM_GEN_DPI_ABORT_EN adds abort)
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TYPE_W    = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [TYPE_W-1:0]    in_type,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic                 out_illegal,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  if (XLEN != 32 && XLEN != 64) begin : g_xlen_bad
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end
  logic [XLEN-1:0] dec_imm, main_imm, skid_imm;
  logic            dec_ill, main_ill, skid_ill;
  logic            in_x, out_x;
  skid_state_e     state;
  imm_decode #(.XLEN(XLEN), .TYPE_W(TYPE_W)) u_dec (
    .inst    (in_inst),
    .typ     (in_type),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );
  assign in_ready    = state != FULL;
  assign out_valid   = state != EMPTY;
  assign out_imm     = main_imm;
  assign out_illegal = main_ill;
  assign in_x        = in_valid && in_ready;
  assign out_x       = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      main_imm <= '0;
      main_ill <= 1'b0;
      skid_imm <= '0;
      skid_ill <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (in_x && (state == EMPTY || out_x)) begin
        main_imm <= dec_imm;
        main_ill <= dec_ill;
      end else if (state == FULL && out_x) begin
        main_imm <= skid_imm;
        main_ill <= skid_ill;
      end
      if (in_x && state == ONE && !out_x) begin
        skid_imm <= dec_imm;
        skid_ill <= dec_ill;
      end
      state <= state == EMPTY ? (in_x ? ONE : EMPTY) :
               state == ONE   ? (in_x && !out_x ? FULL : !in_x && out_x ? EMPTY : ONE) :
               (out_x ? ONE : FULL);
      if (in_x && dec_ill && err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`ifdef IMM_GEN_DPI_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst_n && in_x && dec_ill) $fatal(1, "ebreak code=%0d data=%h unit=%0d", ABORT, 32'hdeafbeaf, UNIT_IE4);
  end
`endif
endmodule
